// File: rtl/grid_judge_if.sv
// Board/result bundle between the marker/recorder (master) and the tic-tac-toe judge (slave).
interface grid_judge_if;
  localparam int unsigned CELLS  = 9;
  localparam int unsigned GRID_W = 2 * CELLS;
  localparam int unsigned LINE_W = 3;

  logic [GRID_W-1:0] game_grid;
  logic              start;
  logic              busy;
  logic              result_valid;
  logic [1:0]        winner;
  logic [LINE_W-1:0] win_line;
  logic [CELLS-1:0]  highlight;
  logic              game_over;

  modport master (
    output game_grid, start,
    input  busy, result_valid, winner, win_line, highlight, game_over
  );

  modport slave (
    input  game_grid, start,
    output busy, result_valid, winner, win_line, highlight, game_over
  );
endinterface

// File: rtl/grid_judge.sv
// Tic-tac-toe judge: snapshots the board on change, scans the 8 lines one per cycle,
// then reports the first winning line per player; a win latches until start.
module grid_judge (
  input  logic       clk,
  input  logic       reset,
  grid_judge_if.slave bus
);
  localparam int unsigned CELLS  = 9;
  localparam int unsigned GRID_W = 2 * CELLS;
  localparam int unsigned LINE_W = 3;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT, OVER} state_t;

  state_t            state;
  logic [GRID_W-1:0] snapshot;
  logic [LINE_W-1:0] line_idx;
  logic              a_hit;
  logic              b_hit;
  logic [LINE_W-1:0] a_line;
  logic [LINE_W-1:0] b_line;

  // Cell mask of each line, rows then columns then diagonals.
  function automatic logic [CELLS-1:0] line_mask(input logic [LINE_W-1:0] idx);
    logic [CELLS-1:0] m;
    case (idx)
      3'd0:    m = 9'h007;
      3'd1:    m = 9'h038;
      3'd2:    m = 9'h1C0;
      3'd3:    m = 9'h049;
      3'd4:    m = 9'h092;
      3'd5:    m = 9'h124;
      3'd6:    m = 9'h111;
      default: m = 9'h054;
    endcase
    return m;
  endfunction

  logic [CELLS-1:0] cur_mask_c;
  logic             a_line_hit_c;
  logic             b_line_hit_c;
  logic [CELLS-1:0] win_mask_c;
  logic [LINE_W-1:0] rep_line_c;

  always_comb begin
    cur_mask_c   = line_mask(line_idx);
    a_line_hit_c = (snapshot[CELLS-1:0] & cur_mask_c) == cur_mask_c;
    b_line_hit_c = (snapshot[GRID_W-1:CELLS] & cur_mask_c) == cur_mask_c;
    rep_line_c   = a_hit ? a_line : (b_hit ? b_line : LINE_W'(0));
    win_mask_c   = (a_hit || b_hit) ? line_mask(rep_line_c) : CELLS'(0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      snapshot         <= GRID_W'(0);
      line_idx         <= LINE_W'(0);
      a_hit            <= 1'b0;
      b_hit            <= 1'b0;
      a_line           <= LINE_W'(0);
      b_line           <= LINE_W'(0);
      bus.busy         <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.winner       <= 2'b00;
      bus.win_line     <= LINE_W'(0);
      bus.highlight    <= CELLS'(0);
      bus.game_over    <= 1'b0;
    end else begin
      bus.result_valid <= 1'b0;
      if (bus.start) begin
        // New game wins over everything, including a simultaneous board change.
        state         <= IDLE;
        snapshot      <= GRID_W'(0);
        line_idx      <= LINE_W'(0);
        a_hit         <= 1'b0;
        b_hit         <= 1'b0;
        bus.busy      <= 1'b0;
        bus.winner    <= 2'b00;
        bus.win_line  <= LINE_W'(0);
        bus.highlight <= CELLS'(0);
        bus.game_over <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.game_grid != snapshot) begin
              snapshot <= bus.game_grid;
              line_idx <= LINE_W'(0);
              a_hit    <= 1'b0;
              b_hit    <= 1'b0;
              bus.busy <= 1'b1;
              state    <= SCAN;
            end
          end
          SCAN: begin
            if (bus.game_grid != snapshot) begin
              snapshot <= bus.game_grid;
              line_idx <= LINE_W'(0);
              a_hit    <= 1'b0;
              b_hit    <= 1'b0;
            end else begin
              if (a_line_hit_c && !a_hit) begin
                a_hit  <= 1'b1;
                a_line <= line_idx;
              end
              if (b_line_hit_c && !b_hit) begin
                b_hit  <= 1'b1;
                b_line <= line_idx;
              end
              line_idx <= line_idx + LINE_W'(1);
              if (line_idx == LINE_W'(7)) begin
                bus.busy <= 1'b0;
                state    <= REPORT;
              end
            end
          end
          REPORT: begin
            bus.result_valid <= 1'b1;
            bus.winner       <= {b_hit, a_hit};
            bus.win_line     <= rep_line_c;
            bus.highlight    <= win_mask_c;
            if (a_hit || b_hit) begin
              bus.game_over <= 1'b1;
              state         <= OVER;
            end else begin
              state <= IDLE;
            end
          end
          OVER: begin
            state <= OVER;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_grid_judge.sv
// Bench for grid_judge: directed scenarios plus randomized boards against a line-table model.
module tb_grid_judge;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  grid_judge_if bus ();

  grid_judge dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned line_cells [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                     '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  logic [17:0] m_snap;
  logic        m_over;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: scan the line table, first completed line per player wins.
  function automatic void model(input logic [17:0] g, output logic [1:0] w,
                                output logic [2:0] l, output logic [8:0] h);
    int a_first = -1;
    int b_first = -1;
    for (int i = 0; i < 8; i++) begin
      bit a = 1'b1;
      bit b = 1'b1;
      for (int j = 0; j < 3; j++) begin
        a &= g[line_cells[i][j]];
        b &= g[line_cells[i][j] + 9];
      end
      if (a && a_first < 0) a_first = i;
      if (b && b_first < 0) b_first = i;
    end
    w = {b_first >= 0, a_first >= 0};
    l = (a_first >= 0) ? 3'(a_first) : ((b_first >= 0) ? 3'(b_first) : 3'd0);
    h = '0;
    if (w != 2'b00)
      for (int j = 0; j < 3; j++) h[line_cells[l][j]] = 1'b1;
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, ".busy"}, 32'(bus.busy), 32'(0));
    check({tag, ".rv"}, 32'(bus.result_valid), 32'(0));
    check({tag, ".winner"}, 32'(bus.winner), 32'(0));
    check({tag, ".win_line"}, 32'(bus.win_line), 32'(0));
    check({tag, ".highlight"}, 32'(bus.highlight), 32'(0));
    check({tag, ".game_over"}, 32'(bus.game_over), 32'(0));
  endtask

  // Present a board and expect exactly one strobe ten sampled edges later.
  task automatic run_scan(input logic [17:0] g, input string tag);
    logic [1:0] w;
    logic [2:0] l;
    logic [8:0] h;
    int n = 0;
    bit seen = 1'b0;
    bus.game_grid = g;
    while (n < 20 && !seen) begin
      step();
      n++;
      if (n == 1) check({tag, ".busy_on"}, 32'(bus.busy), 32'(1));
      if (bus.result_valid === 1'b1) seen = 1'b1;
    end
    check({tag, ".latency"}, 32'(n), 32'(10));
    model(g, w, l, h);
    check({tag, ".winner"}, 32'(bus.winner), 32'(w));
    check({tag, ".win_line"}, 32'(bus.win_line), 32'(l));
    check({tag, ".highlight"}, 32'(bus.highlight), 32'(h));
    check({tag, ".game_over"}, 32'(bus.game_over), 32'(w != 2'b00));
    check({tag, ".busy_off"}, 32'(bus.busy), 32'(0));
    step();
    check({tag, ".strobe_end"}, 32'(bus.result_valid), 32'(0));
    m_snap = g;
    m_over = (w != 2'b00);
  endtask

  task automatic new_game(input logic [17:0] g, input string tag);
    bus.start     = 1'b1;
    bus.game_grid = g;
    step();
    bus.start = 1'b0;
    check_cleared(tag);
    m_snap = '0;
    m_over = 1'b0;
  endtask

  // Idle for n cycles and require no strobe and unchanged outputs.
  task automatic quiet(input int n, input string tag);
    logic [1:0] w0 = bus.winner;
    logic [8:0] h0 = bus.highlight;
    logic       o0 = bus.game_over;
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) pulses++;
    end
    check({tag, ".no_scan"}, 32'(pulses), 32'(0));
    check({tag, ".winner_held"}, 32'(bus.winner), 32'(w0));
    check({tag, ".highlight_held"}, 32'(bus.highlight), 32'(h0));
    check({tag, ".game_over_held"}, 32'(bus.game_over), 32'(o0));
  endtask

  initial begin
    logic [17:0] g;
    int pulses;
    checks        = 0;
    errors        = 0;
    m_snap        = '0;
    m_over        = 1'b0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.game_grid = '0;
    #2;
    check_cleared("reset");
    step();
    reset = 1'b1;
    step();

    run_scan(18'h00007, "row_win");
    quiet(12, "over_hold_a");
    new_game(18'h0, "start1");
    run_scan(18'h0A800, "diag_win");
    new_game(18'h0, "start2");
    run_scan(18'h00003, "no_win");
    quiet(12, "unchanged");
    run_scan(18'h00007, "after_no_win");

    new_game(18'h0, "start3");
    bus.game_grid = 18'h00003;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.result_valid !== 1'b0) pulses++;
    end
    check("midscan.early_pulse", 32'(pulses), 32'(0));
    run_scan(18'h00007, "midscan");

    bus.game_grid = 18'h00000;
    quiet(12, "over_grid_change");
    new_game(18'h0, "start4");
    run_scan(18'h00038, "mid_row");

    new_game(18'h0, "start5");
    bus.game_grid = 18'h00007;
    step();
    step();
    step();
    reset = 1'b0;
    #1;
    check_cleared("reset_midscan");
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.result_valid !== 1'b0) pulses++;
    end
    check("reset_midscan.no_pulse", 32'(pulses), 32'(0));
    reset  = 1'b1;
    m_snap = '0;
    m_over = 1'b0;
    run_scan(18'h00007, "after_reset");

    // Start with a simultaneous change: change is picked up on the following cycle.
    new_game(18'h0A800, "start_prio");
    run_scan(18'h0A800, "start_prio_scan");

    for (int it = 0; it < 12; it++) begin
      new_game(18'h0, "rand_start");
      for (int k = 0; k < 3 && !m_over; k++) begin
        g = 18'($urandom) & 18'($urandom);
        if ($urandom_range(0, 2) == 0) begin
          int unsigned ln = $urandom_range(0, 7);
          int unsigned off = $urandom_range(0, 1) * 9;
          for (int j = 0; j < 3; j++) g[line_cells[ln][j] + off] = 1'b1;
        end
        if (g == m_snap) g[0] = ~g[0];
        run_scan(g, "rand");
      end
      if (m_over) begin
        bus.game_grid = 18'($urandom);
        quiet(11, "rand_over");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
